// File: rtl/detector_jogada.sv
// Player-button front end: 2-flop synchronizer, stability debounce, and a
// press/evaluate/hold FSM that emits one play per press. `MULTI_PRESS_ERROR_EN
// enables the jogada_invalida pulse for stable multi-button presses.
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       tem_jogada,
    output logic       jogada_invalida,
    output logic [1:0] db_estado
);

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        AVALIA = 2'd1,
        SEGURA = 2'd2
    } estado_t;

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sync1_q, sync2_q;
    logic [3:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] deb_q, deb_d;
    logic [3:0] jogada_q, jogada_d;
    estado_t    estado_q, estado_d;
    logic       tem_jogada_d, jogada_invalida_d;
    logic       one_hot;

    // Candidate restarts the count on any change; counter saturates at CNT_MAX.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = cand_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign one_hot = (deb_q != 4'd0) && ((deb_q & (deb_q - 4'd1)) == 4'd0);

    always_comb begin
        estado_d          = estado_q;
        jogada_d          = jogada_q;
        tem_jogada_d      = 1'b0;
        jogada_invalida_d = 1'b0;
        case (estado_q)
            ESPERA: if (deb_q != 4'd0) estado_d = AVALIA;
            AVALIA: begin
                estado_d = SEGURA;
                if (habilita && one_hot) begin
                    jogada_d     = deb_q;
                    tem_jogada_d = 1'b1;
                end
`ifdef MULTI_PRESS_ERROR_EN
                else if (habilita && deb_q != 4'd0) begin
                    jogada_invalida_d = 1'b1;
                end
`endif
            end
            SEGURA: if (deb_q == 4'd0) estado_d = ESPERA;
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            deb_q    <= '0;
            jogada_q <= '0;
            estado_q <= ESPERA;
        end else begin
            sync1_q  <= botoes;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            deb_q    <= deb_d;
            jogada_q <= jogada_d;
            estado_q <= estado_d;
        end
    end

    assign jogada          = jogada_q;
    assign tem_jogada      = tem_jogada_d;
    assign jogada_invalida = jogada_invalida_d;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: window-based debounce model checked every cycle,
// directed scenarios with literal latency/count pins, then random presses.
module tb_detector_jogada;

    localparam int D   = 20;
    localparam int WIN = D + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] botoes = 4'd0;
    logic       habilita = 1'b1;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       jogada_invalida;
    logic [1:0] db_estado;

    detector_jogada #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clk),
        .reset(rst_n),
        .botoes(botoes),
        .habilita(habilita),
        .jogada(jogada),
        .tem_jogada(tem_jogada),
        .jogada_invalida(jogada_invalida),
        .db_estado(db_estado)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int npulse = 0;
    int ninv = 0;
    int last_pulse = -1000;

`ifdef MULTI_PRESS_ERROR_EN
    localparam int INV_EN = 1;
`else
    localparam int INV_EN = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_oh(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    // Model: debounced value is v once the samples taken D+2..2 edges ago
    // (D+1 samples, accounting for the synchronizer) are all equal to v.
    logic [3:0] hist [0:WIN-1];
    logic [3:0] deb_m = 4'd0;
    logic [3:0] jog_m = 4'd0;
    int         st_m  = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) hist[i] = 4'd0;
            deb_m = 4'd0;
            jog_m = 4'd0;
            st_m  = 0;
        end else begin
            int  nst;
            bit  same;
            nst = st_m;
            if (st_m == 0) nst = (deb_m != 0) ? 1 : 0;
            else if (st_m == 1) begin
                nst = 2;
                if (habilita && is_oh(deb_m)) jog_m = deb_m;
            end else nst = (deb_m == 0) ? 0 : 2;
            for (int i = WIN - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = botoes;
            same = 1'b1;
            for (int i = 3; i < WIN; i++) if (hist[i] != hist[2]) same = 1'b0;
            if (same) deb_m = hist[2];
            st_m = nst;
        end
    end

    always @(negedge clk) begin
        int exp_tem, exp_inv;
        exp_tem = (st_m == 1 && habilita && is_oh(deb_m)) ? 1 : 0;
        exp_inv = (INV_EN == 1 && st_m == 1 && habilita && deb_m != 0 && !is_oh(deb_m)) ? 1 : 0;
        chk("tem_jogada", int'(tem_jogada), exp_tem);
        chk("jogada_invalida", int'(jogada_invalida), exp_inv);
        chk("jogada", int'(jogada), int'(jog_m));
        chk("db_estado", int'(db_estado), st_m);
        chk("exclusive", int'(tem_jogada & jogada_invalida), 0);
        if (tem_jogada) begin
            npulse++;
            last_pulse = cyc;
        end
        if (jogada_invalida) ninv++;
    end

    task automatic hold(input logic [3:0] v, input int n, input bit rnd_hab);
        botoes = v;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (rnd_hab && $urandom_range(0, 15) == 0) habilita = ~habilita;
        end
    endtask

    initial begin
        int start, p0, i0;
        for (int i = 0; i < WIN; i++) hist[i] = 4'd0;
        repeat (3) begin @(negedge clk); #1; end
        chk("rst_jogada", int'(jogada), 0);
        chk("rst_tem", int'(tem_jogada), 0);
        chk("rst_estado", int'(db_estado), 0);
        rst_n = 1'b1;
        hold(4'd0, 5, 0);

        // single press: latency, held value, exactly one pulse
        start = cyc + 1;
        hold(4'b0010, 100, 0);
        chk("lat_press", last_pulse - start, 23);
        chk("jog_press", int'(jogada), 4'b0010);
        hold(4'd0, 40, 0);
        chk("npulse_press", npulse, 1);
        chk("estado_idle", int'(db_estado), 0);

        // short glitch
        p0 = npulse;
        hold(4'b0100, 10, 0);
        hold(4'd0, 30, 0);
        chk("glitch_np", npulse, p0);
        chk("glitch_jog", int'(jogada), 4'b0010);

        // long hold then slide to another button without release
        hold(4'b0001, 500, 0);
        hold(4'b1000, 100, 0);
        hold(4'd0, 40, 0);
        chk("slide_np", npulse, p0 + 1);
        chk("slide_jog", int'(jogada), 4'b0001);

        // two buttons at once
        p0 = npulse;
        i0 = ninv;
        hold(4'b0011, 100, 0);
        hold(4'd0, 40, 0);
        chk("multi_np", npulse, p0);
        chk("multi_inv", ninv, i0 + INV_EN);

        // disabled, then enabled
        habilita = 1'b0;
        i0 = ninv;
        hold(4'b1000, 100, 0);
        hold(4'd0, 40, 0);
        chk("dis_np", npulse, p0);
        chk("dis_inv", ninv, i0);
        chk("dis_jog", int'(jogada), 4'b0001);
        habilita = 1'b1;
        hold(4'b0100, 60, 0);
        hold(4'd0, 40, 0);
        chk("ena_np", npulse, p0 + 1);
        chk("ena_jog", int'(jogada), 4'b0100);

        // reset in the middle of a press
        p0 = npulse;
        hold(4'b0010, 15, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_jog", int'(jogada), 0);
        chk("midrst_tem", int'(tem_jogada), 0);
        chk("midrst_estado", int'(db_estado), 0);
        repeat (3) begin @(negedge clk); #1; end
        rst_n = 1'b1;
        start = cyc + 1;
        hold(4'b0010, 40, 0);
        chk("midrst_np", npulse, p0 + 1);
        chk("midrst_lat", last_pulse - start, 23);
        hold(4'd0, 40, 0);

        // random presses with habilita jitter and occasional resets
        for (int s = 0; s < 300; s++) begin
            int r;
            logic [3:0] v;
            r = $urandom_range(0, 9);
            if (r < 4) v = 4'd0;
            else if (r < 8) v = 4'(1 << $urandom_range(0, 3));
            else if (r == 8) v = 4'($urandom_range(0, 15));
            else v = 4'b0011 << $urandom_range(0, 2);
            hold(v, $urandom_range(1, 45), 1);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                hold(v, $urandom_range(1, 3), 0);
                rst_n = 1'b1;
            end
        end
        hold(4'd0, 40, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
